// File: rtl/pipeline_pkg.sv
// Shared defaults, occupancy-width helper and parameter-range checks for the
// parametrised pipeline stage and its skid FIFO.
package pipeline_pkg;

    localparam int PIPE_WIDTH_DEF = 32;
    localparam int PIPE_DEPTH_DEF = 2;
    localparam int PIPE_DEPTH_MAX = 64;

    // Bits needed to hold an entry count of 0..depth inclusive.
    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic bit depth_ok(input int depth);
        return (depth >= 1) && (depth <= PIPE_DEPTH_MAX);
    endfunction

    function automatic bit thresh_ok(input int depth, input int thresh);
        return (thresh >= 1) && (thresh <= depth);
    endfunction

endpackage

// File: rtl/pipeline_skid_fifo.sv
// DEPTH-entry skid FIFO with synchronous clear; pointers wrap at DEPTH so
// non-power-of-two depths work, and a full FIFO may read and write together.
module pipeline_skid_fifo
    import pipeline_pkg::*;
#(
    parameter int WIDTH = PIPE_WIDTH_DEF,
    parameter int DEPTH = PIPE_DEPTH_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      wr_en,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic                      rd_en,
    output logic [WIDTH-1:0]          rd_data,
    output logic [occ_w(DEPTH)-1:0]   count,
    output logic                      empty,
    output logic                      full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = occ_w(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q + CNT_W'(wr_en) - CNT_W'(rd_en);
        if (wr_en) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (rd_en) rd_ptr_d = ptr_inc(rd_ptr_q);
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (wr_en && !clear) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = cnt_q;
    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CNT_W'(DEPTH));

endmodule

// File: rtl/pipeline_unit_param.sv
// Parametrised pipeline stage: output register fed directly or from a skid
// FIFO, flush forwarding, threshold stall. PIPE_UNIT_OCC_EN exposes out_occupancy.
module pipeline_unit_param
    import pipeline_pkg::*;
#(
    parameter int WIDTH        = PIPE_WIDTH_DEF,
    parameter int DEPTH        = PIPE_DEPTH_DEF,
    parameter int STALL_THRESH = DEPTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_flush,
    input  logic [WIDTH-1:0]        inputs,
    input  logic                    in_valid,
    input  logic                    in_stall,
    output logic [WIDTH-1:0]        outputs,
    output logic                    out_valid,
    output logic                    out_flush,
    output logic                    out_stall
`ifdef PIPE_UNIT_OCC_EN
    ,
    output logic [occ_w(DEPTH)-1:0] out_occupancy
`endif
);

    localparam int CNT_W = occ_w(DEPTH);

    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("pipeline_unit_param: DEPTH out of range 1..64");
    end
    if (!thresh_ok(DEPTH, STALL_THRESH)) begin : g_bad_thresh
        $error("pipeline_unit_param: STALL_THRESH out of range 1..DEPTH");
    end

    logic             hold, fire, enq, deq;
    logic             empty, full;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] head, nxt_word;

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             flush_q, flush_d;

    // Once the FIFO holds anything, new words must queue behind it to keep order.
    always_comb begin
        hold     = in_stall & valid_q;
        fire     = (in_valid | !empty) & !hold;
        deq      = fire & !empty;
        enq      = in_valid & (!fire | !empty) & (!full | deq);
        nxt_word = empty ? inputs : head;
    end

    always_comb begin
        data_d  = data_q;
        valid_d = hold | fire;
        flush_d = 1'b0;
        if (fire) data_d = nxt_word;
        if (in_flush) begin
            data_d  = '0;
            valid_d = 1'b0;
            flush_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            flush_q <= flush_d;
        end
    end

    pipeline_skid_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .clear   (in_flush),
        .wr_en   (enq),
        .wr_data (inputs),
        .rd_en   (deq),
        .rd_data (head),
        .count   (count),
        .empty   (empty),
        .full    (full)
    );

    assign outputs   = data_q;
    assign out_valid = valid_q;
    assign out_flush = flush_q;
    assign out_stall = (count >= CNT_W'(STALL_THRESH));
`ifdef PIPE_UNIT_OCC_EN
    assign out_occupancy = count;
`endif

endmodule

// File: tb/tb_pipeline_unit_param.sv
// Directed bench for pipeline_unit_param (WIDTH=32, DEPTH=4, STALL_THRESH=3)
// with a queue scoreboard checked on every downstream transfer.
module tb_pipeline_unit_param;

    logic        clk = 1'b0;
    logic        reset, in_flush, in_valid, in_stall;
    logic [31:0] inputs, outputs;
    logic        out_valid, out_flush, out_stall;
    logic [2:0]  occ;

    int vectors     = 0;
    int miscompares = 0;
    logic [31:0] sb_q [$];

    pipeline_unit_param #(.WIDTH(32), .DEPTH(4), .STALL_THRESH(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_flush  (in_flush),
        .inputs    (inputs),
        .in_valid  (in_valid),
        .in_stall  (in_stall),
        .outputs   (outputs),
        .out_valid (out_valid),
        .out_flush (out_flush),
        .out_stall (out_stall)
`ifdef PIPE_UNIT_OCC_EN
        ,
        .out_occupancy (occ)
`endif
    );

`ifndef PIPE_UNIT_OCC_EN
    assign occ = dut.count;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d);
        in_valid = v;
        inputs   = d;
        if (v) sb_q.push_back(d);
    endtask

    // Scoreboard: a word leaves the stage on the edge after a cycle with out_valid & !in_stall.
    always @(negedge clk) begin
        if (!reset && !in_flush) begin
            if (in_valid && occ == 3'd4 && in_stall && out_valid) begin
                miscompares++;
                $error("FAIL protocol: word offered to full stalled FIFO");
            end
            if (out_valid && !in_stall) begin
                if (sb_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $error("FAIL spurious: observed %h expected none", outputs);
                end else begin
                    chk("sb_order", outputs, sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        reset = 1'b1; in_flush = 1'b0; in_valid = 1'b0; in_stall = 1'b0; inputs = '0;
        #12;
        chk("rst_outputs", outputs, 32'h0);
        chk("rst_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_flush", {31'b0, out_flush}, 32'h0);
        chk("rst_stall", {31'b0, out_stall}, 32'h0);
        chk("rst_occ", {29'b0, occ}, 32'h0);
        reset = 1'b0;

        // Bypass stream, one-cycle latency
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'hA0 + i);
            tick();
            chk("bypass_data", outputs, 32'hA0 + i);
            chk("bypass_valid", {31'b0, out_valid}, 32'h1);
            chk("bypass_occ", {29'b0, occ}, 32'h0);
        end
        drive(1'b0, '0);
        tick();
        chk("bypass_valid_end", {31'b0, out_valid}, 32'h0);

        // Stall: first word lands in output reg, the rest queue
        in_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h10 + i);
            tick();
            chk("stall_hold", outputs, 32'h10);
            chk("stall_occ", {29'b0, occ}, 32'(i));
            chk("stall_flag", {31'b0, out_stall}, (i >= 3) ? 32'h1 : 32'h0);
        end
        drive(1'b0, '0);
        in_stall = 1'b0;
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("release_data", outputs, 32'h10 + i);
            chk("release_occ", {29'b0, occ}, 32'(3 - i));
            chk("release_stall", {31'b0, out_stall}, 32'h0);
        end
        tick();
        chk("release_idle", {31'b0, out_valid}, 32'h0);

        // Full FIFO: simultaneous deq/enq
        in_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h20 + i);
            tick();
        end
        chk("full_occ", {29'b0, occ}, 32'h4);
        chk("full_stall", {31'b0, out_stall}, 32'h1);
        in_stall = 1'b0;
        drive(1'b1, 32'h55);
        tick();
        chk("full_swap_occ", {29'b0, occ}, 32'h4);
        chk("full_swap_data", outputs, 32'h21);
        drive(1'b0, '0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("full_drain", outputs, (i == 3) ? 32'h55 : 32'h22 + i);
        end
        tick();
        chk("full_idle", {31'b0, out_valid}, 32'h0);

        // Flush with count = 3 and out_valid = 1
        in_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h30 + i);
            tick();
        end
        chk("pre_flush_occ", {29'b0, occ}, 32'h3);
        in_flush = 1'b1;
        in_valid = 1'b1;
        inputs   = 32'h99;
        tick();
        sb_q.delete();
        chk("flush_fwd", {31'b0, out_flush}, 32'h1);
        chk("flush_valid", {31'b0, out_valid}, 32'h0);
        chk("flush_data", outputs, 32'h0);
        chk("flush_occ", {29'b0, occ}, 32'h0);
        chk("flush_stall", {31'b0, out_stall}, 32'h0);
        in_flush = 1'b0;
        drive(1'b0, '0);
        in_stall = 1'b0;
        tick();
        chk("flush_clear", {31'b0, out_flush}, 32'h0);

        // Asynchronous reset mid-stream with count = 2
        in_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h40 + i);
            tick();
        end
        chk("pre_rst_occ", {29'b0, occ}, 32'h2);
        drive(1'b0, '0);
        #2 reset = 1'b1;
        #1;
        sb_q.delete();
        chk("arst_data", outputs, 32'h0);
        chk("arst_valid", {31'b0, out_valid}, 32'h0);
        chk("arst_stall", {31'b0, out_stall}, 32'h0);
        chk("arst_occ", {29'b0, occ}, 32'h0);
        #2 reset = 1'b0;
        in_stall = 1'b0;
        drive(1'b1, 32'hB0);
        tick();
        chk("post_rst_data", outputs, 32'hB0);
        chk("post_rst_valid", {31'b0, out_valid}, 32'h1);
        drive(1'b0, '0);
        tick();
        tick();

        chk("sb_drained", 32'(sb_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
